midi_note_decoder: RTL and testbench
====================================

# midi_note_decoder

Parses an incoming MIDI byte stream into monophonic note events for the envelope generator stage. Tracks running status, filters on a MIDI channel, applies last-note priority, and emits single-cycle `note_on` / `note_off` pulses plus a held `gate`, note number and velocity. Sits between the UART byte receiver and the envelope generator; its `note_on` / `note_off` outputs connect directly to the envelope generator's inputs of the same name.

## Interface

Parameters:
- `CHANNEL`, default 0: MIDI channel (0-15) accepted when `OMNI` = 0.
- `OMNI`, default 0: 1 means channel-voice messages on all channels are accepted.

Ports:
- `clk`  input  1  system clock.
- `rst_b`  input  1  reset. Asynchronous, active-low.
- `rx_data`  input  8  received MIDI byte.
- `rx_valid`  input  1  `rx_data` is valid this cycle. One byte is consumed per cycle in which this is high.
- `note_on`  output  1  one-cycle pulse: a new note has started.
- `note_off`  output  1  one-cycle pulse: the held note has been released.
- `gate`  output  1  high while a note is held.
- `note`  output  7  current or last note number.
- `velocity`  output  7  velocity of the last accepted note-on.

## Operation

- Parser states are WAIT_STATUS, DATA1 and DATA2. Registers: `run_status[7:0]` and `d1[6:0]`.
- A byte with bit7 = 1 and value 0x80–0xEF is a channel status byte:
  - Load it into `run_status`.
  - Go to DATA1 from any state. A partially received message is discarded.
- Bytes 0xF0–0xF7 (system common / SysEx):
  - Clear `run_status` to 0x00.
  - Go to WAIT_STATUS.
- Bytes 0xF8–0xFF (real-time) are ignored completely. No state or register changes.
- A data byte (bit7 = 0) is handled by state:
  - In WAIT_STATUS with `run_status` = 0: ignored.
  - In WAIT_STATUS with `run_status` != 0: treated as DATA1 (running status).
  - In DATA1: store the byte in `d1`. Go to DATA2 for message types 8,9,A,B,E; go to WAIT_STATUS for types C,D (these are complete and discarded).
  - In DATA2: the message is complete; go to WAIT_STATUS. `run_status` is kept for running status.
- A completed message is acted on only if the channel matches: `run_status[3:0]` == `CHANNEL`, or `OMNI` = 1.
- Note-on (type 9, velocity > 0):
  - `note` <= `d1`, `velocity` <= data2, `gate` <= 1.
  - Pulse `note_on`.
  - This also happens when a note is already held (retrigger, last-note priority). `note_off` is not pulsed in that case.
- Note-off (type 8, or type 9 with velocity 0):
  - If `gate` = 1 and `d1` == `note`: `gate` <= 0 and pulse `note_off`.
  - Otherwise the message is ignored. `note` and `velocity` keep their values.
- Types A, B and E are parsed for length only and produce no action.

## Timing

- Reset values: `note_on` = 0, `note_off` = 0, `gate` = 0, `note` = 0, `velocity` = 0, `run_status` = 0x00, state = WAIT_STATUS.
- All outputs are registered.
- Latency: the event is reflected on outputs in the cycle after the final data byte is sampled with `rx_valid` = 1.
  - `note_on` / `note_off` are high for exactly that one cycle.
  - `gate`, `note` and `velocity` update in that same cycle.
- `note_on` and `note_off` are never high in the same cycle.
- Back-to-back bytes on consecutive cycles must be supported with no stall. There is no ready signal; every byte with `rx_valid` high is consumed.
- `rx_valid` = 0 holds the parser state indefinitely. There is no timeout.
- Reset asserted mid-message or while `gate` = 1:
  - All outputs and parser state go to reset values immediately (asynchronously).
  - No `note_off` pulse is generated.
  - After reset release, data bytes are ignored until a status byte arrives.

## Test plan

1. Send 0x90 0x3C 0x64 with `CHANNEL` = 0 -> one-cycle `note_on`, `gate` = 1, `note` = 0x3C, `velocity` = 0x64. Then send 0x80 0x3C 0x00 -> one-cycle `note_off`, `gate` = 0.
2. Running status: 0x90 0x3C 0x64, then 0x40 0x50, then 0x40 0x00 ->
   - second `note_on` with `note` = 0x40, `velocity` = 0x50;
   - then `note_off`, `gate` = 0.
3. Last-note priority: note-on 0x3C, note-on 0x40, note-off 0x3C ->
   - two `note_on` pulses;
   - no `note_off` pulse;
   - `gate` stays 1 with `note` = 0x40.
4. Channel filter: 0x91 0x3C 0x64 with `CHANNEL` = 0, `OMNI` = 0 -> no pulse, `gate` = 0. The same stimulus with `OMNI` = 1 -> `note_on`.
5. Interleaving:
   - 0x90 0xF8 0x3C 0xFE 0x64 (real-time bytes inside a message) -> `note_on` with `note` = 0x3C.
   - 0x90 0x3C 0xF0 0x64 -> no event, `run_status` cleared. A following 0x3C 0x64 is ignored.
6. Reset while `gate` = 1 -> all outputs 0 immediately. After release, 0x3C 0x64 is ignored. Then 0x90 0x3C 0x64 -> `note_on`.

Source files
------------

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser producing monophonic note events.
// Running status, channel filter, last-note priority.
module midi_note_decoder #(
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_on,
  output logic       note_off,
  output logic       gate,
  output logic [6:0] note,
  output logic [6:0] velocity
);

  typedef enum logic [1:0] {
    WAIT_STATUS = 2'd0,
    DATA1       = 2'd1,
    DATA2       = 2'd2
  } state_e;

  localparam logic [3:0] CH = 4'(CHANNEL);

  state_e     state_q, state_d;
  logic [7:0] run_status_q, run_status_d;
  logic [6:0] d1_q, d1_d;
  logic       note_on_q, note_on_d;
  logic       note_off_q, note_off_d;
  logic       gate_q, gate_d;
  logic [6:0] note_q, note_d;
  logic [6:0] vel_q, vel_d;

  logic [3:0] typ;
  logic       chan_ok;
  logic       two_byte;
  logic       take_d1;
  logic       is_chan;
  logic       is_sys;
  logic       is_rt;
  logic       is_data;
  logic [6:0] d2;

  assign typ      = run_status_q[7:4];
  assign chan_ok  = OMNI || (run_status_q[3:0] == CH);
  assign two_byte = (typ != 4'hC) && (typ != 4'hD);
  assign take_d1  = (state_q == DATA1) ||
                    ((state_q == WAIT_STATUS) &&
                     (run_status_q != 8'h00));
  assign is_data  = !rx_data[7];
  assign is_chan  = rx_data[7] && (rx_data[7:4] != 4'hF);
  assign is_sys   = (rx_data[7:3] == 5'b11110);
  assign is_rt    = (rx_data[7:3] == 5'b11111);
  assign d2       = rx_data[6:0];

  // Byte classification, parser transitions and note actions
  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    d1_d         = d1_q;
    note_on_d    = 1'b0;
    note_off_d   = 1'b0;
    gate_d       = gate_q;
    note_d       = note_q;
    vel_d        = vel_q;
    if (rx_valid) begin
      unique case (1'b1)
        is_chan: begin
          run_status_d = rx_data;
          state_d      = DATA1;
        end
        is_sys: begin
          run_status_d = 8'h00;
          state_d      = WAIT_STATUS;
        end
        is_rt: ;
        is_data: begin
          unique case (1'b1)
            state_q == DATA2: begin
              state_d = WAIT_STATUS;
              if (chan_ok) begin
                if (typ == 4'h9 && d2 != 7'd0) begin
                  note_d    = d1_q;
                  vel_d     = d2;
                  gate_d    = 1'b1;
                  note_on_d = 1'b1;
                end else if ((typ == 4'h8 || typ == 4'h9) &&
                             gate_q && (d1_q == note_q)) begin
                  gate_d     = 1'b0;
                  note_off_d = 1'b1;
                end
              end
            end
            take_d1: begin
              d1_d    = rx_data[6:0];
              state_d = two_byte ? DATA2 : WAIT_STATUS;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= WAIT_STATUS;
      run_status_q <= 8'h00;
      d1_q         <= 7'd0;
      note_on_q    <= 1'b0;
      note_off_q   <= 1'b0;
      gate_q       <= 1'b0;
      note_q       <= 7'd0;
      vel_q        <= 7'd0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      d1_q         <= d1_d;
      note_on_q    <= note_on_d;
      note_off_q   <= note_off_d;
      gate_q       <= gate_d;
      note_q       <= note_d;
      vel_q        <= vel_d;
    end
  end

  assign note_on  = note_on_q;
  assign note_off = note_off_q;
  assign gate     = gate_q;
  assign note     = note_q;
  assign velocity = vel_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder.
// Two instances: channel 0 filtered, and omni.
module tb_midi_note_decoder;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       note_on, note_off, gate;
  logic [6:0] note, velocity;
  logic       o_note_on, o_note_off, o_gate;
  logic [6:0] o_note, o_velocity;

  int passed = 0;
  int total = 0;
  int on_cnt = 0;
  int off_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  midi_note_decoder #(.CHANNEL(0), .OMNI(1'b0)) dut (
    .clk(clk), .rst_b(rst_b),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(note_on), .note_off(note_off),
    .gate(gate), .note(note), .velocity(velocity)
  );

  midi_note_decoder #(.CHANNEL(0), .OMNI(1'b1)) dut_omni (
    .clk(clk), .rst_b(rst_b),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(o_note_on), .note_off(o_note_off),
    .gate(o_gate), .note(o_note), .velocity(o_velocity)
  );

  always @(negedge clk) begin
    if (note_on) on_cnt++;
    if (note_off) off_cnt++;
    if (note_on && note_off) both_cnt++;
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({note_on, note_off, gate, note, velocity} !== 17'd0)
      $display("FAIL reset_outs got=%h want=0",
               {note_on, note_off, gate, note, velocity});
    else passed++;
    @(negedge clk);
    rst_b = 1'b1;
    idle();
  endtask

  task automatic test_channel();
    send(8'h91); send(8'h3C); send(8'h64); idle();
    total++;
    if (note_on !== 1'b0 || gate !== 1'b0)
      $display("FAIL chan_filter got=%b%b want=00", note_on, gate);
    else passed++;
    total++;
    if (o_note_on !== 1'b1 || o_note !== 7'h3C)
      $display("FAIL chan_omni got=%b/%h want=1/3c", o_note_on, o_note);
    else passed++;
    idle();
  endtask

  task automatic test_basic();
    send(8'h90); send(8'h3C); send(8'h64); idle();
    total++;
    if ({note_on, note_off, gate, note, velocity} !== {3'b101, 7'h3C, 7'h64})
      $display("FAIL basic_on got=%b%b%b/%h/%h want=101/3c/64",
               note_on, note_off, gate, note, velocity);
    else passed++;
    idle();
    total++;
    if (note_on !== 1'b0 || gate !== 1'b1)
      $display("FAIL basic_pulse got=%b%b want=01", note_on, gate);
    else passed++;
    send(8'h80); send(8'h3C); send(8'h00); idle();
    total++;
    if ({note_on, note_off, gate} !== 3'b010)
      $display("FAIL basic_off got=%b want=010", {note_on, note_off, gate});
    else passed++;
    idle();
    total++;
    if (note_off !== 1'b0 || note !== 7'h3C || velocity !== 7'h64)
      $display("FAIL basic_hold got=%b/%h/%h want=0/3c/64",
               note_off, note, velocity);
    else passed++;
  endtask

  task automatic test_running_status();
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h40); send(8'h50); idle();
    total++;
    if ({note_on, gate, note, velocity} !== {2'b11, 7'h40, 7'h50})
      $display("FAIL run_on got=%b%b/%h/%h want=11/40/50",
               note_on, gate, note, velocity);
    else passed++;
    send(8'h40); send(8'h00); idle();
    total++;
    if ({note_on, note_off, gate} !== 3'b010)
      $display("FAIL run_off got=%b want=010", {note_on, note_off, gate});
    else passed++;
    idle();
  endtask

  task automatic test_last_note();
    int on0, off0;
    on0 = on_cnt;
    off0 = off_cnt;
    send(8'h90); send(8'h3C); send(8'h64);
    send(8'h40); send(8'h70);
    send(8'h80); send(8'h3C); send(8'h40);
    idle(); idle();
    total++;
    if (on_cnt - on0 !== 2 || off_cnt - off0 !== 0)
      $display("FAIL last_pulses got=%0d/%0d want=2/0",
               on_cnt - on0, off_cnt - off0);
    else passed++;
    total++;
    if (gate !== 1'b1 || note !== 7'h40 || velocity !== 7'h70)
      $display("FAIL last_held got=%b/%h/%h want=1/40/70",
               gate, note, velocity);
    else passed++;
    send(8'h90); send(8'h40); send(8'h00); idle();
    total++;
    if (note_off !== 1'b1 || gate !== 1'b0)
      $display("FAIL last_release got=%b%b want=10", note_off, gate);
    else passed++;
    idle();
  endtask

  task automatic test_interleave();
    int on0;
    send(8'h90); send(8'hF8); send(8'h3C);
    send(8'hFE); send(8'h64); idle();
    total++;
    if (note_on !== 1'b1 || note !== 7'h3C || velocity !== 7'h64)
      $display("FAIL rt_inside got=%b/%h/%h want=1/3c/64",
               note_on, note, velocity);
    else passed++;
    send(8'h80); send(8'h3C); send(8'h00); idle();
    on0 = on_cnt;
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h64);
    send(8'h3C); send(8'h64); idle(); idle();
    total++;
    if (on_cnt - on0 !== 0 || gate !== 1'b0)
      $display("FAIL sysex_abort got=%0d/%b want=0/0",
               on_cnt - on0, gate);
    else passed++;
  endtask

  task automatic test_short_msgs();
    int on0;
    on0 = on_cnt;
    send(8'hC0); send(8'h05); send(8'h3C); send(8'h64);
    idle(); idle();
    total++;
    if (on_cnt - on0 !== 0 || gate !== 1'b0)
      $display("FAIL prog_change got=%0d/%b want=0/0",
               on_cnt - on0, gate);
    else passed++;
    send(8'hB0); send(8'h07); send(8'h7F);
    send(8'h90); send(8'h3C); send(8'h64); idle();
    total++;
    if (note_on !== 1'b1 || gate !== 1'b1)
      $display("FAIL after_cc got=%b%b want=11", note_on, gate);
    else passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    int off0, on0;
    off0 = off_cnt;
    #2;
    rst_b = 1'b0;
    #1;
    total++;
    if ({note_on, note_off, gate, note, velocity} !== 17'd0)
      $display("FAIL async_reset got=%h want=0",
               {note_on, note_off, gate, note, velocity});
    else passed++;
    @(negedge clk);
    rst_b = 1'b1;
    total++;
    if (off_cnt - off0 !== 0)
      $display("FAIL reset_no_off got=%0d want=0", off_cnt - off0);
    else passed++;
    on0 = on_cnt;
    send(8'h3C); send(8'h64); idle(); idle();
    total++;
    if (on_cnt - on0 !== 0 || gate !== 1'b0)
      $display("FAIL post_reset_data got=%0d/%b want=0/0",
               on_cnt - on0, gate);
    else passed++;
    send(8'h90); send(8'h3C); send(8'h64); idle();
    total++;
    if (note_on !== 1'b1 || note !== 7'h3C)
      $display("FAIL post_reset_on got=%b/%h want=1/3c", note_on, note);
    else passed++;
    idle();
  endtask

  initial begin
    test_reset();
    test_channel();
    test_basic();
    test_running_status();
    test_last_note();
    test_interleave();
    test_short_msgs();
    test_reset_mid();
    total++;
    if (both_cnt !== 0)
      $display("FAIL on_off_overlap got=%0d want=0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
